// File: rtl/board_debug_pkg.sv
// Shared types and constants for the board debug controller: step state,
// fixed button roles and the display-select width helper.
package board_debug_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } stepState_e;

  localparam int BTN_STEP = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_PREV = 2;
  localparam int BTN_AUTO = 3;

  function automatic int selWidth(input int numSrc);
    return (numSrc <= 2) ? 1 : $clog2(numSrc);
  endfunction

endpackage

// File: rtl/board_debug_ctrl_debounce.sv
// One pushbutton channel: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle press strobe that trails the level rise by one clock.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clock,
  input  logic reset,
  input  logic btnRaw,
  output logic btnLevel,
  output logic btnPress
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             syncMeta;
  logic             syncStable;
  logic             levelDly;
  logic [CNT_W-1:0] stableCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      syncMeta   <= 1'b0;
      syncStable <= 1'b0;
      levelDly   <= 1'b0;
      btnLevel   <= 1'b0;
      btnPress   <= 1'b0;
      stableCnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its source, which is what turns these two lines into a real 2-stage sync.
      syncMeta   <= ~btnRaw;
      syncStable <= syncMeta;
      levelDly   <= btnLevel;
      btnPress   <= btnLevel & ~levelDly;

      // Any disagreement must persist DEBOUNCE_CYCLES clocks; a bounce restarts it.
      if (syncStable == btnLevel) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btnLevel  <= syncStable;
        stableCnt <= '0;
      end else begin
        stableCnt <= stableCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_debug_ctrl.sv
// Board debug controller: debounced buttons, manual/auto processor stepping
// and a wrap-around hex-display source selector, all in one clock domain.
module board_debug_ctrl
  import board_debug_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int NUM_SRC         = 4,
  parameter int SRC_W           = 32,
  parameter int AUTO_DIV_W      = 24,
  parameter int STEP_CNT_W      = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_BTN-1:0]                btn_raw,
  input  logic                              run_enable,
  input  logic [AUTO_DIV_W-1:0]             auto_period,
  input  logic [NUM_SRC*SRC_W-1:0]          src_data,
  output logic [NUM_BTN-1:0]                btn_level,
  output logic [NUM_BTN-1:0]                btn_press,
  output logic                              step_pulse,
  output logic [STEP_CNT_W-1:0]             step_count,
  output logic                              auto_active,
  output logic [selWidth(NUM_SRC)-1:0]      display_sel,
  output logic [SRC_W-1:0]                  display_data
);

  localparam int SEL_W = selWidth(NUM_SRC);

  stepState_e            state;
  logic [AUTO_DIV_W-1:0] periodCnt;
  logic [SEL_W-1:0]      nextSel;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .btnRaw  (btn_raw[i]),
      .btnLevel(btn_level[i]),
      .btnPress(btn_press[i])
    );
  end

  // The switch freezes everything: no pulses, counter parked, state kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= MANUAL;
      periodCnt  <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (!run_enable) begin
        periodCnt <= '0;
      end else begin
        case (state)
          MANUAL: begin
            step_pulse <= btn_press[BTN_STEP];
            if (btn_press[BTN_AUTO]) begin
              state     <= AUTO;
              periodCnt <= '0;
            end
          end
          AUTO: begin
            if (btn_press[BTN_AUTO]) begin
              state     <= MANUAL;
              periodCnt <= '0;
            end else if (periodCnt >= auto_period) begin
              step_pulse <= 1'b1;
              periodCnt  <= '0;
            end else begin
              periodCnt <= periodCnt + AUTO_DIV_W'(1);
            end
          end
          default: state <= MANUAL;
        endcase
      end
    end
  end

  assign auto_active = (state == AUTO);

  always_ff @(posedge clock) begin
    if (reset) begin
      step_count <= '0;
    end else begin
      step_count <= step_count + STEP_CNT_W'(step_pulse);
    end
  end

  always_comb begin
    // NOTE: assigning a default first guarantees every path drives nextSel,
    // so no latch is inferred for the unlisted case combinations.
    nextSel = display_sel;
    case ({btn_press[BTN_PREV], btn_press[BTN_NEXT]})
      2'b01:   nextSel = (display_sel == SEL_W'(NUM_SRC - 1)) ? '0 : display_sel + SEL_W'(1);
      2'b10:   nextSel = (display_sel == '0) ? SEL_W'(NUM_SRC - 1) : display_sel - SEL_W'(1);
      default: nextSel = display_sel;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      display_sel  <= '0;
      display_data <= '0;
    end else begin
      display_sel  <= nextSel;
      display_data <= src_data[display_sel*SRC_W +: SRC_W];
    end
  end

endmodule

// File: doc/board_debug_ctrl.md
Name: board_debug_ctrl

Overview:
Parametrised board-level debug controller between the board pushbuttons/switches and the processor core. It debounces NUM_BTN raw buttons in the system clock domain and produces one-cycle press strobes. It generates processor step enables (manual single-step or timed auto-run) and steps through NUM_SRC hex-display sources with next/prev buttons. It replaces button-as-clock stepping and fixed 4-way display muxing with a single-clock-domain, wrap-around, N-channel design.

Parameters:
NUM_BTN, 4, number of pushbutton channels (min 4; channels 0-3 have fixed functions, the rest are debounce-only)
DEBOUNCE_CYCLES, 270000, consecutive stable clocks required to accept a new level (10 ms at 27 MHz)
NUM_SRC, 4, number of display sources (>=2)
SRC_W, 32, width of each display source
AUTO_DIV_W, 24, width of the auto-run period value
STEP_CNT_W, 16, width of the step counter

Ports:
clock  in  1  system clock (clk_27 domain)
reset  in  1  synchronous, active-high reset
btn_raw  in  NUM_BTN  raw pushbuttons, active-low (pressed = 0), asynchronous to clock
run_enable  in  1  master enable for step generation (switch)
auto_period  in  AUTO_DIV_W  auto-run pulse spacing minus one
src_data  in  NUM_SRC*SRC_W  packed display sources, source k at [k*SRC_W +: SRC_W]
btn_level  out  NUM_BTN  debounced level, 1 = pressed
btn_press  out  NUM_BTN  one-cycle strobe on each debounced press
step_pulse  out  1  one-cycle processor step enable
step_count  out  STEP_CNT_W  number of step_pulse cycles since reset
auto_active  out  1  1 while in AUTO state
display_sel  out  clog2(NUM_SRC)  current display source index
display_data  out  SRC_W  registered selected source

Behaviour:
- Reset: btn_level=0, btn_press=0, step_pulse=0, step_count=0, auto_active=0, display_sel=0, display_data=0, state=MANUAL. All debounce counters and period counter=0, sync flops loaded with "released".
- Input path: each btn_raw bit is inverted and passes through a 2-flop synchroniser. The debounce counter clears whenever the synchronised value equals btn_level. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, btn_level takes the new value and the counter clears. A bounce resets the count.
- btn_press[i] is high for exactly the cycle after btn_level[i] goes 0->1. Release produces no strobe.
- Latency: a clean press is visible on btn_level 2+DEBOUNCE_CYCLES clocks after the raw edge, and on btn_press one clock later.
- Fixed button functions: btn 0 = step, btn 1 = next source, btn 2 = previous source, btn 3 = toggle auto-run.
- State machine (encoded MANUAL=0, AUTO=1):
  - MANUAL: btn_press[0] && run_enable -> step_pulse=1 next cycle. btn_press[3] -> AUTO, period counter cleared.
  - AUTO: the period counter increments each cycle while run_enable=1. When the counter equals auto_period, step_pulse=1 and the counter clears. auto_period=0 gives a pulse every cycle. btn_press[0] is ignored. btn_press[3] -> MANUAL, no pulse that cycle.
  - run_enable=0 in either state: no step_pulse, period counter held at 0, state unchanged.
  - auto_period lowered below the current count: the pulse fires on the next cycle and the counter clears (compare is >=).
- step_pulse never lasts more than one cycle in MANUAL. step_count increments on every step_pulse cycle and wraps from all-ones to 0.
- Display: btn_press[1] gives display_sel+1, wrapping NUM_SRC-1 -> 0. btn_press[2] gives display_sel-1, wrapping 0 -> NUM_SRC-1. Simultaneous presses on 1 and 2 leave display_sel unchanged.
- display_data is registered each cycle from the source indexed by the current display_sel. It follows a select change one clock later and a src_data change one clock later.
- Reset asserted mid-debounce, mid-auto-period or mid-press returns everything to reset values on the next edge. A button held through reset is re-accepted after full debounce and then produces one btn_press.

Decomposition:
- Package board_debug_pkg: state enum (MANUAL, AUTO); button index constants BTN_STEP=0, BTN_NEXT=1, BTN_PREV=2, BTN_AUTO=3; function for the display_sel width (clog2).
- Sub-module debounce_channel (synchroniser + counter + level + press strobe, parameter DEBOUNCE_CYCLES), instantiated NUM_BTN times in a generate loop.
- The step FSM, period counter and display selector live in the top module.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4.
- Reset released, btn_raw[0] low with 3-cycle bounces then stable low, run_enable=1 -> exactly one btn_press[0] and one step_pulse 7 clocks after the stable edge; step_count=1.
- MANUAL, run_enable=0, five clean presses of btn 0 -> no step_pulse; step_count stays 0.
- Press btn 3, auto_period=2, run_enable=1 for 12 cycles -> auto_active=1, step_pulse every 3rd cycle (4 pulses), no pulse in any other cycle. Press btn 3 again -> auto_active=0 and pulses stop.
- NUM_SRC=4, display_sel=3, press btn 1 -> sel=0; press btn 2 -> sel=3. Press btns 1 and 2 on the same cycle -> sel unchanged. display_data equals source 3 (e.g. 32'hDEADBEEF) one clock after sel=3.
- step_count preset near wrap via 65535 auto pulses (auto_period=0) -> step_count reaches 16'hFFFF, then 0 on the next pulse.
- Assert reset during AUTO at count 1 with btn 0 held -> all outputs return to reset values. After release, btn_level[0] rises after 6 clocks with a single btn_press[0], and no step_pulse until it is pressed in MANUAL.
